// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions.
//   RESET_PC      - PC value after reset
//   INSTR_BYTES   - PC increment per sequential fetch
//   NOP_INSTR     - encoding used when an instruction slot must be filled
//   fetch_entry_t - {pc, instr} pair handed from fetch to decode
package cpu_pkg;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, power-of-two depth.
//   clk, rst    - clock, asynchronous active-high reset
//   push, din   - write request and data (accepted when not full, or full with a pop)
//   pop, dout   - read request; dout shows the head entry whenever not empty
//   flush       - empties the FIFO; push/pop that cycle are ignored
//   full, empty, count - occupancy status
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Storage needs no reset: nothing is read until count says it was written.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage between the PC register and decode.
//   clk, rst                       - clock, asynchronous active-high reset
//   pc / next_pc                   - current PC in, value the PC register loads next
//   imem_req_valid/ready, imem_addr - in-order fetch requests at pc
//   imem_rsp_valid, imem_rsp_data  - in-order responses (>= 1 cycle after acceptance)
//   redirect_valid, redirect_pc    - taken branch/jump; flushes queued and in-flight work
//   id_valid/ready, id_instr, id_pc - {pc, instr} handshake towards decode
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc,
  output logic [AW-1:0] next_pc,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_rsp_valid,
  input  logic [DW-1:0] imem_rsp_data,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          id_valid,
  input  logic          id_ready,
  output logic [DW-1:0] id_instr,
  output logic [AW-1:0] id_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]    outstanding;
  logic [CW-1:0]    discard;
  logic [CW-1:0]    q_count;
  logic [CW-1:0]    tag_count;
  logic [CW+1:0]    in_use;
  logic             credit_ok;
  logic             req_fire;
  logic             rsp_drop;
  logic             rsp_keep;
  logic             q_pop;
  logic             q_full;
  logic             q_empty;
  logic             tag_full;
  logic             tag_empty;
  logic [AW-1:0]    tag_pc;
  logic [AW+DW-1:0] q_din;
  logic [AW+DW-1:0] q_dout;

  // Every slot is either queued, in flight, or owed to a discarded response;
  // limiting the sum to DEPTH is what keeps the queue from ever overflowing.
  assign in_use    = (CW+2)'(outstanding) + (CW+2)'(q_count) + (CW+2)'(discard);
  assign credit_ok = (in_use < (CW+2)'(DEPTH));

  assign imem_req_valid = credit_ok & ~redirect_valid & ~rst;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign imem_addr      = pc;

  // A response landing in the redirect cycle belongs to the old path.
  assign rsp_drop = imem_rsp_valid & (redirect_valid | (discard != '0));
  assign rsp_keep = imem_rsp_valid & ~rsp_drop;
  assign q_pop    = id_valid & id_ready & ~redirect_valid;

  always_comb begin
    next_pc = pc;
    if (redirect_valid)
      next_pc = {redirect_pc[AW-1:2], 2'b00};
    else if (req_fire)
      next_pc = pc + AW'(INSTR_BYTES);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      // Recomputed from outstanding so back-to-back redirects never double count.
      if (redirect_valid)
        discard <= outstanding - CW'(imem_rsp_valid);
      else if (imem_rsp_valid && (discard != '0))
        discard <= discard - CW'(1);
    end
  end

  // Tags are never flushed: discarded responses still pop their own tag.
  sync_fifo #(.W(AW), .DEPTH(DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_fire),
    .pop   (imem_rsp_valid),
    .flush (1'b0),
    .din   (pc),
    .dout  (tag_pc),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  assign q_din = {tag_pc, imem_rsp_data};

  sync_fifo #(.W(AW+DW), .DEPTH(DEPTH)) u_instr_q (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_keep),
    .pop   (q_pop),
    .flush (redirect_valid),
    .din   (q_din),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign id_valid = ~q_empty;
  assign id_pc    = q_dout[AW+DW-1:DW];
  assign id_instr = q_dout[DW-1:0];

  a_rsp_without_request: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (outstanding != '0));
  a_rsp_into_full_queue: assert property (@(posedge clk) disable iff (rst)
    rsp_keep |-> !q_full);
  a_rsp_without_tag: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> !tag_empty);
  a_tag_overflow: assert property (@(posedge clk) disable iff (rst)
    req_fire |-> !tag_full);
  a_tag_tracks_outstanding: assert property (@(posedge clk) disable iff (rst)
    tag_count == outstanding);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int DEPTH = 2;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] pc = '0;
  logic [AW-1:0] next_pc;
  logic          imem_req_valid;
  logic          imem_req_ready = 1'b1;
  logic [AW-1:0] imem_addr;
  logic          imem_rsp_valid = 1'b0;
  logic [DW-1:0] imem_rsp_data = '0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          id_valid;
  logic          id_ready = 1'b1;
  logic [DW-1:0] id_instr;
  logic [AW-1:0] id_pc;

  fetch_unit #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .next_pc        (next_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned   c;
    logic [AW-1:0] a;
  } pend_t;

  pend_t       pend[$];
  int unsigned cyc = 0;
  bit          mem_en = 1'b1;
  int unsigned mem_lat = 1;
  int          ntests = 0;
  int          nfail = 0;
  int          nfires = 0;

  function automatic logic [DW-1:0] instr_of(input logic [AW-1:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // One clock: sample the request side mid-cycle, then model the PC register
  // and a memory that answers in order after mem_lat cycles.
  task automatic step();
    logic          f;
    logic [AW-1:0] fa;
    logic [AW-1:0] np;
    @(negedge clk);
    f  = imem_req_valid & imem_req_ready;
    fa = imem_addr;
    np = next_pc;
    @(posedge clk);
    #1;
    cyc++;
    imem_rsp_valid = 1'b0;
    if (rst) begin
      pc = RESET_PC;
      pend.delete();
    end else begin
      pc = np;
      if (f) begin
        pend.push_back('{cyc, fa});
        nfires++;
      end
      if (mem_en && pend.size() > 0 && (cyc - pend[0].c + 1 >= mem_lat)) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(pend[0].a);
        pend.delete(0);
      end
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    pc             = RESET_PC;
    pend.delete();
    step();
    step();
    rst = 1'b0;
    settle();
  endtask

  initial begin
    logic [AW-1:0] got[$];
    int            base;
    bit            found;

    // ---------------- reset state ----------------
    #2;
    rst = 1'b1;
    #1;
    chk("rst_id_valid", 64'(id_valid), 64'd0);
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    do_reset();
    chk("post_rst_req_valid", 64'(imem_req_valid), 64'd1);
    chk("post_rst_addr", 64'(imem_addr), 64'h0);
    chk("post_rst_next_pc", 64'(next_pc), 64'h4);

    // ---------------- sequential stream ----------------
    id_ready = 1'b1; imem_req_ready = 1'b1; mem_en = 1'b1; mem_lat = 1;
    for (int i = 0; i < 20; i++) begin
      settle();
      if (id_valid) begin
        if (got.size() < 4)
          chk($sformatf("t1_instr_%0d", got.size()), 64'(id_instr), 64'(instr_of(id_pc)));
        got.push_back(id_pc);
      end
      step();
    end
    chk("t1_count_min", 64'(got.size() >= 9), 64'd1);
    if (got.size() >= 4) begin
      chk("t1_pc0", 64'(got[0]), 64'h0);
      chk("t1_pc1", 64'(got[1]), 64'h4);
      chk("t1_pc2", 64'(got[2]), 64'h8);
      chk("t1_pc3", 64'(got[3]), 64'hC);
    end else begin
      chk("t1_too_few", 64'(got.size()), 64'd4);
    end

    // ---------------- decode stall ----------------
    do_reset();
    id_ready = 1'b0;
    base = nfires;
    step(); step();
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("t2_hold_pc_%0d", i), 64'(id_pc), 64'h0);
      step();
    end
    settle();
    chk("t2_fires", 64'(nfires - base), 64'(DEPTH));
    chk("t2_req_valid", 64'(imem_req_valid), 64'd0);
    chk("t2_next_pc_hold", 64'(next_pc), 64'(pc));
    chk("t2_pc", 64'(pc), 64'h8);
    chk("t2_instr", 64'(id_instr), 64'(instr_of(32'h0)));
    id_ready = 1'b1;
    settle();
    chk("t2_release_pc", 64'(id_pc), 64'h0);
    step();
    settle();
    chk("t2_second_valid", 64'(id_valid), 64'd1);
    chk("t2_second_pc", 64'(id_pc), 64'h4);

    // ---------------- redirect with two outstanding ----------------
    do_reset();
    mem_en = 1'b0;
    pc = 32'h10;
    settle();
    step(); step();
    settle();
    chk("t3_credit_stall", 64'(imem_req_valid), 64'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    settle();
    chk("t3_next_pc", 64'(next_pc), 64'h100);
    chk("t3_redir_no_req", 64'(imem_req_valid), 64'd0);
    mem_en = 1'b1;
    step();
    redirect_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      settle();
      if (id_valid) begin
        found = 1'b1;
        chk("t3_first_pc", 64'(id_pc), 64'h100);
        chk("t3_first_instr", 64'(id_instr), 64'(instr_of(32'h100)));
      end else begin
        step();
      end
    end
    if (!found) chk("t3_timeout", 64'd0, 64'd1);

    // ---------------- redirect with response and pop ----------------
    do_reset();
    mem_en = 1'b1; id_ready = 1'b1;
    step(); step();
    settle();
    chk("t4_pre_valid", 64'(id_valid), 64'd1);
    chk("t4_pre_pc", 64'(id_pc), 64'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    settle();
    chk("t4_next_pc", 64'(next_pc), 64'h200);
    step();
    redirect_valid = 1'b0;
    settle();
    chk("t4_queue_empty", 64'(id_valid), 64'd0);
    chk("t4_req_after", 64'(imem_req_valid), 64'd1);
    chk("t4_next_pc_after", 64'(next_pc), 64'h204);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      settle();
      if (id_valid) begin
        found = 1'b1;
        chk("t4_first_pc", 64'(id_pc), 64'h200);
      end else begin
        step();
      end
    end
    if (!found) chk("t4_timeout", 64'd0, 64'd1);

    // ---------------- PC wrap ----------------
    do_reset();
    pc = 32'hFFFF_FFFC;
    settle();
    chk("t5_req_valid", 64'(imem_req_valid), 64'd1);
    chk("t5_next_pc_wrap", 64'(next_pc), 64'h0);
    step(); step();
    settle();
    chk("t5_id_pc", 64'(id_pc), 64'hFFFF_FFFC);
    chk("t5_id_instr", 64'(id_instr), 64'(instr_of(32'hFFFF_FFFC)));

    // ---------------- asynchronous reset mid-burst ----------------
    do_reset();
    step(); step();
    settle();
    chk("t6_pre_valid", 64'(id_valid), 64'd1);
    #1;
    rst            = 1'b1;
    imem_rsp_valid = 1'b0;
    pend.delete();
    pc             = RESET_PC;
    #1;
    chk("t6_rst_id_valid", 64'(id_valid), 64'd0);
    chk("t6_rst_req_valid", 64'(imem_req_valid), 64'd0);
    step();
    rst = 1'b0;
    settle();
    chk("t6_restart_req", 64'(imem_req_valid), 64'd1);
    chk("t6_restart_addr", 64'(imem_addr), 64'h0);
    step(); step();
    settle();
    chk("t6_restart_valid", 64'(id_valid), 64'd1);
    chk("t6_restart_pc", 64'(id_pc), 64'h0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that sits between the PC register and decode. Each cycle it computes the value loaded into the PC register. It issues in-order instruction-memory requests at the current PC and buffers the returned instructions with their PCs in a small queue. It presents those {pc, instr} pairs to decode under a valid/ready handshake. Branch/jump redirects flush the queue and discard in-flight responses.

Parameters:
DEPTH, 2, maximum number of instructions either buffered in the queue or outstanding at instruction memory (credit limit); power of two, at least 2.
AW, 32, address/PC width.
DW, 32, instruction width.

Ports:
clk  in  1  clock
rst  in  1  reset
pc  in  AW  current PC from the PC register (reset value 0)
next_pc  out  AW  value the PC register loads on the next clk edge
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  instruction memory accepts the request
imem_addr  out  AW  fetch address; always equal to pc
imem_rsp_valid  in  1  response valid; responses arrive in request order, at least 1 cycle after acceptance
imem_rsp_data  in  DW  returned instruction
redirect_valid  in  1  taken branch/jump from a later stage
redirect_pc  in  AW  redirect target
id_valid  out  1  instruction available to decode
id_ready  in  1  decode accepts
id_instr  out  DW  instruction at head of queue
id_pc  out  AW  PC of id_instr

Interface: reset rst, asynchronous, active-high; clock clk. All state is cleared on the rising edge of rst.

Behaviour:
- State: outstanding counter (0..DEPTH), discard counter (0..DEPTH), PC-tag FIFO holding the PC of each outstanding request, and an instruction queue of DEPTH entries holding {pc, instr}.
- Reset values: all counters 0; both FIFOs empty; id_valid 0; imem_req_valid 0.
- credit_ok = (outstanding + queue_count + discard) < DEPTH.
- imem_req_valid = credit_ok & ~redirect_valid.
- req_fire = imem_req_valid & imem_req_ready.
- On req_fire: push pc into the tag FIFO and increment outstanding.
- next_pc priority:
  - redirect_valid: {redirect_pc[AW-1:2], 2'b00}.
  - otherwise, req_fire: pc + 4, wrapping modulo 2^AW (0xFFFFFFFC -> 0).
  - otherwise: pc (hold).
- Response, discard > 0: drop the data, decrement discard and outstanding, pop the tag FIFO.
- Response, discard == 0: pop the tag and push {tag, imem_rsp_data} into the queue. The entry becomes visible on id_* the next cycle, so rsp-to-id_valid latency is 1 cycle and there is no bypass.
- Overflow: the queue can never overflow because of the credit rule. A response arriving with a full queue is a protocol violation and must be flagged by an assertion.
- id_valid = queue not empty. On id_valid & id_ready: pop the head. id_instr and id_pc stay stable while id_valid & ~id_ready.
- Redirect cycle:
  - The queue is cleared and any pop that cycle is ignored.
  - No request is issued.
  - discard <= outstanding − (1 if a response arrives this cycle).
  - A response arriving in the redirect cycle is itself dropped.
  - The tag FIFO is not cleared; it drains as discarded responses arrive.
- Back-to-back redirects: the last redirect_pc wins. discard accumulates correctly because it is recomputed from outstanding each time.
- Simultaneous push and pop on the queue in the same cycle is allowed; the count stays unchanged.
- Reset mid-operation: all counters and FIFOs clear immediately. Any response arriving after reset release while outstanding == 0 is illegal; assert on it.

Decomposition:
- Shared package cpu_pkg:
  - RESET_PC = 32'h0000_0000
  - INSTR_BYTES = 4
  - NOP_INSTR = 32'h0000_0000
  - fetch-entry struct {pc, instr}
- One natural sub-module: sync_fifo (parameterised width and depth; push, pop, flush, full, empty, count; asynchronous active-high rst).
  - Instantiated twice: tag FIFO with flush tied low, and instruction queue with flush = redirect_valid.

Test Plan:
- Reset, then imem always ready with 1-cycle latency and id_ready=1 -> id_pc sequence 0x0, 0x4, 0x8, 0xC. Steady-state throughput 1 instr per 2 cycles at DEPTH=2; must match DEPTH−1 rsp-latency bound.
- id_ready held 0 -> at most DEPTH instructions fetched, then imem_req_valid=0 and next_pc == pc (hold). id_pc/id_instr stable until id_ready=1.
- Two requests outstanding (pc 0x10, 0x14), redirect to 0x103 -> next_pc=0x100; both late responses dropped. The first id_pc after the redirect is 0x100 with its instruction.
- Redirect in the same cycle a response and a decode pop occur -> queue empty next cycle; discard = outstanding−1; no stale instr ever has id_valid=1.
- PC at 0xFFFFFFFC, request accepted -> next_pc=0x0.
- rst asserted asynchronously mid-burst -> id_valid and imem_req_valid go 0 immediately. After release, fetch restarts from pc=0x0.
